nibble_capture: RTL and testbench
=================================

# nibble_capture

- Downstream consumer of the 4-bit serial-in shift register.
- Watches the same serial bit stream the register shifts in (SIN) and the register's parallel taps (SHQ).
- Aligns to a SYNC marker, assembles each 4-bit group into a nibble, and buffers nibbles in a small FIFO.
- Presents buffered nibbles on a valid/ready handshake to the next stage.

## Interface
- FIFO_DEPTH, 2: nibble buffer entries; power of two, at least 2.
- FRAME_NIBS, 0: nibbles per frame after SYNC; 0 means continuous capture until the next SYNC.
- CLK  in  1  single clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- BIT_EN  in  1  high in every cycle where the shift register shifts SIN in; tie high when the register shifts every clock.
- SIN  in  1  serial bit, the same net as the shift register's D input.
- SYNC  in  1  qualified by BIT_EN; marks SIN as bit 0 of a frame.
- SHQ  in  4  shift-register parallel output, Q[3..0].
- NIB  out  4  head-of-FIFO nibble; bit 0 is the first received bit.
- NIB_VALID  out  1  FIFO not empty.
- NIB_READY  in  1  consumer accepts NIB when NIB_VALID and NIB_READY are both high.
- OVF  out  1  sticky; set when a nibble completes while the FIFO is full.
- PERR  out  1  one-cycle parity error pulse; exists only when parity is compiled in.

## Operation
- States:
  - HUNT: ignore bits until a SYNC bit.
  - RECV: bit counter cnt runs 0..3.
  - PAR: one parity bit; compiled in only with the parity macro.
- HUNT -> RECV on BIT_EN & SYNC; SIN is taken as bit 0 and cnt becomes 1.
- RECV: each BIT_EN increments cnt. The 4th bit (cnt==3) completes the nibble {SIN, SHQ[3:1]}; this combinational value is pushed into the FIFO on that edge.
- After a nibble completes:
  - without parity: cnt wraps to 0 and the state stays RECV;
  - with parity: go to PAR.
- Frame counter: when FRAME_NIBS>0, after FRAME_NIBS nibbles go to HUNT; the counter is cleared on SYNC.
- SYNC in RECV or PAR: the partial nibble is discarded, SIN becomes bit 0 of a new frame, cnt becomes 1. No error is flagged.
- Cycles without BIT_EN hold all counters and the state.
- FIFO full at push:
  - the nibble is dropped and OVF is set;
  - a simultaneous pop frees a slot, so the push succeeds and OVF is not set.
- FIFO empty: NIB_VALID low and NIB is don't-care; a push and a pop in the same cycle on an empty FIFO pops nothing.
- OVF clears only on reset.

## Timing
- Reset values: state HUNT, cnt 0, FIFO empty, NIB_VALID 0, NIB 4'h0, OVF 0, PERR 0.
- Latency: NIB_VALID rises on the edge that clocks in the 4th bit; the nibble is visible one cycle after that bit is presented. No added latency when the FIFO is non-empty.
- Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- Throughput: one push and one pop per cycle.
- Reset mid-frame: everything returns to reset values immediately, and buffered nibbles are lost.

## Configuration
- NIBCAP_PARITY_EN
  - Defined:
    - each nibble is followed by one even-parity bit; XOR of the 4 data bits and the parity bit must be 0;
    - in PAR, the BIT_EN bit is checked and PERR pulses for one cycle on mismatch;
    - the nibble is still buffered whether or not parity passes;
    - then return to RECV, or to HUNT if the frame is complete.
  - Undefined: no PAR state, no PERR port, nibbles are back-to-back.

## Structure
- Shared package holds the state typedef (HUNT, RECV, PAR) and the localparam NIB_W = 4.
- One sub-module, nib_fifo: parameterised synchronous FIFO with push/pop/full/empty and occupancy.
- The top level holds the FSM, bit counter, frame counter, parity, and the OVF logic.

## Test plan
- SYNC+bits 1,0,1,1 at BIT_EN=1 every cycle -> NIB=4'hD, NIB_VALID high one cycle after the 4th bit.
- NIB_READY=0, continuous stream 8'hA5 then 4'h3 with FIFO_DEPTH=2 -> FIFO holds 5, A; the third nibble is dropped and OVF=1. Raising NIB_READY drains 5 then A.
- BIT_EN toggling 1/0 with the same stream -> nibbles identical to the BIT_EN=1 case, at half rate.
- SYNC after 2 bits of a frame -> partial discarded; the next nibble is built from the 4 bits starting at the SYNC.
- FRAME_NIBS=2: three nibbles sent after one SYNC -> only 2 buffered; a second SYNC resumes capture.
- Parity build: nibble 4'h7 with parity bit 0 -> PERR pulses once and 7 is still delivered. With parity bit 1 -> no PERR.

Source files
------------

// File: rtl/nibble_capture_pkg.sv
// Shared types and constants for the nibble capture block.
//   state_t : capture FSM states (HUNT, RECV, PAR)
//   NIB_W   : nibble width
package nibble_capture_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_capture_nib_fifo.sv
// nib_fifo: small synchronous FIFO with occupancy count.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write request and data (ignored when full unless a pop frees a slot)
//   pop        : read request (ignored when empty)
//   dout       : head entry
//   empty      : no entries held
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module nib_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full_c;
  logic          pop_ok_c;
  logic          push_ok_c;

  // A pop in the same cycle frees a slot for a push into a full FIFO;
  // a pop on an empty FIFO does nothing even if a push lands that cycle.
  assign full_c    = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign pop_ok_c  = pop & ~empty;
  assign push_ok_c = push & (~full_c | pop_ok_c);
  assign dout      = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok_c) - CW'(pop_ok_c);
    end
  end

endmodule

// File: rtl/nibble_capture.sv
// nibble_capture: aligns to SYNC on a serial stream, assembles 4-bit
// nibbles from SIN plus the shift register taps, and buffers them for a
// valid/ready consumer.
//   CLK, CLR   : clock, async active-low reset
//   BIT_EN     : a serial bit is shifted this cycle
//   SIN, SYNC  : serial bit and frame-start marker (qualified by BIT_EN)
//   SHQ        : shift register parallel taps Q[3:0]
//   NIB        : head nibble, bit 0 first received
//   NIB_VALID  : buffer not empty
//   NIB_READY  : consumer accepts NIB
//   OVF        : sticky overflow (nibble completed while buffer full)
//   PERR       : parity error pulse, present only with NIBCAP_PARITY_EN
// Optional feature macro: NIBCAP_PARITY_EN (one even-parity bit per nibble).
module nibble_capture
  import nibble_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned FRAME_NIBS = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             BIT_EN,
  input  logic             SIN,
  input  logic             SYNC,
  input  logic [NIB_W-1:0] SHQ,
  output logic [NIB_W-1:0] NIB,
  output logic             NIB_VALID,
  input  logic             NIB_READY,
  output logic             OVF
`ifdef NIBCAP_PARITY_EN
  ,
  output logic             PERR
`endif
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FCW = $clog2(FRAME_NIBS + 2);

  state_t           state;
  logic [1:0]       cnt;
  logic [FCW-1:0]   fcnt;
  logic             ovf;

  logic [NIB_W-1:0] nib_c;
  logic             push_c;
  logic             pop_c;
  logic             drop_c;
  logic             frame_done_c;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             shq0_unused;

`ifdef NIBCAP_PARITY_EN
  logic [NIB_W-1:0] par_nib;
  logic             frame_end;
  logic             perr;
`endif

  // SHQ[0] is the oldest tap and falls outside the 4-bit window when SIN lands.
  assign shq0_unused = SHQ[0];

  // Completed nibble: 4th bit is live on SIN, the three earlier bits sit in SHQ[3:1].
  assign nib_c  = {SIN, SHQ[3:1]};
  assign push_c = BIT_EN & ~SYNC & (state == RECV) & (cnt == 2'd3);
  assign pop_c  = NIB_READY & ~fifo_empty;
  assign drop_c = push_c & ~pop_c & (fifo_count == CW'(FIFO_DEPTH));

  // Frame limit reached by the nibble completing this cycle
  assign frame_done_c = (FRAME_NIBS != 0) && ((fcnt + FCW'(1)) == FCW'(FRAME_NIBS));

  // Capture FSM, bit/frame counters, overflow and parity check
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= HUNT;
      cnt   <= '0;
      fcnt  <= '0;
      ovf   <= 1'b0;
`ifdef NIBCAP_PARITY_EN
      par_nib   <= '0;
      frame_end <= 1'b0;
      perr      <= 1'b0;
`endif
    end else begin
`ifdef NIBCAP_PARITY_EN
      perr <= 1'b0;
`endif
      if (drop_c) begin
        ovf <= 1'b1;
      end
      if (BIT_EN) begin
        if (SYNC) begin
          // SYNC always restarts a frame; any partial nibble is discarded.
          state <= RECV;
          cnt   <= 2'd1;
          fcnt  <= '0;
        end else begin
          case (state)
            HUNT: begin
              state <= HUNT;
            end
            RECV: begin
              if (cnt == 2'd3) begin
                cnt  <= '0;
                fcnt <= fcnt + FCW'(1);
`ifdef NIBCAP_PARITY_EN
                par_nib   <= nib_c;
                frame_end <= frame_done_c;
                state     <= PAR;
`else
                if (frame_done_c) begin
                  state <= HUNT;
                end
`endif
              end else begin
                cnt <= cnt + 2'd1;
              end
            end
`ifdef NIBCAP_PARITY_EN
            PAR: begin
              perr  <= ^{par_nib, SIN};
              state <= frame_end ? HUNT : RECV;
            end
`endif
            default: begin
              state <= HUNT;
            end
          endcase
        end
      end
    end
  end

  nib_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (NIB_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (CLR),
    .push  (push_c),
    .pop   (pop_c),
    .din   (nib_c),
    .dout  (NIB),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign NIB_VALID = ~fifo_empty;
  assign OVF       = ovf;
`ifdef NIBCAP_PARITY_EN
  assign PERR      = perr;
`endif

endmodule

// File: tb/tb_nibble_capture.sv
// Directed bench for nibble_capture. Two instances share the stimulus:
// dut (continuous capture) and dut_f (FRAME_NIBS=2). The bench models the
// upstream right-shifting register that feeds SHQ.
module tb_nibble_capture;

  logic       CLK;
  logic       CLR;
  logic       BIT_EN;
  logic       SIN;
  logic       SYNC;
  logic       NIB_READY;
  logic [3:0] shq;

  logic [3:0] nib;
  logic       valid;
  logic       ovf;
  logic [3:0] nib_f;
  logic       valid_f;
  logic       ovf_f;
`ifdef NIBCAP_PARITY_EN
  logic       perr;
  logic       perr_f;
`endif

  int ncmp;
  int nerr;

  nibble_capture #(.FIFO_DEPTH(2), .FRAME_NIBS(0)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .BIT_EN    (BIT_EN),
    .SIN       (SIN),
    .SYNC      (SYNC),
    .SHQ       (shq),
    .NIB       (nib),
    .NIB_VALID (valid),
    .NIB_READY (NIB_READY),
    .OVF       (ovf)
`ifdef NIBCAP_PARITY_EN
    ,
    .PERR      (perr)
`endif
  );

  nibble_capture #(.FIFO_DEPTH(2), .FRAME_NIBS(2)) dut_f (
    .CLK       (CLK),
    .CLR       (CLR),
    .BIT_EN    (BIT_EN),
    .SIN       (SIN),
    .SYNC      (SYNC),
    .SHQ       (shq),
    .NIB       (nib_f),
    .NIB_VALID (valid_f),
    .NIB_READY (NIB_READY),
    .OVF       (ovf_f)
`ifdef NIBCAP_PARITY_EN
    ,
    .PERR      (perr_f)
`endif
  );

  always #5 CLK = ~CLK;

  // Upstream shift register: new bit enters Q[3], oldest leaves Q[0].
  always @(posedge CLK or negedge CLR) begin
    if (!CLR) shq <= 4'h0;
    else if (BIT_EN) shq <= {SIN, shq[3:1]};
  end

  // Present one bit for one cycle; returns at the following falling edge.
  task automatic send_bit(input logic b, input logic s);
    BIT_EN = 1'b1; SIN = b; SYNC = s;
    @(negedge CLK);
    BIT_EN = 1'b0; SIN = 1'b0; SYNC = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Four data bits, LSB first, with optional idle cycles after each bit.
  task automatic send_data(input logic [3:0] n, input logic s, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_bit(n[i], (i == 0) ? s : 1'b0);
      idle(gap);
    end
  endtask

  // Data bits plus a correct parity bit when parity is built in.
  task automatic send_nib(input logic [3:0] n, input logic s);
    send_data(n, s, 0);
`ifdef NIBCAP_PARITY_EN
    send_bit(^n, 1'b0);
`endif
  endtask

  task automatic do_reset();
    CLR = 1'b0; BIT_EN = 1'b0; SIN = 1'b0; SYNC = 1'b0; NIB_READY = 1'b0;
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1;
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", valid); end
    ncmp++; if (nib !== 4'h0) begin nerr++; $display("FAIL reset_nib: got %h want 0", nib); end
    ncmp++; if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    ncmp++; if (valid_f !== 1'b0) begin nerr++; $display("FAIL reset_valid_f: got %b want 0", valid_f); end
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    do_reset();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL basic_early_valid: got %b want 0", valid); end
    send_bit(1'b1, 1'b0);
    ncmp++; if (valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %b want 1", valid); end
    ncmp++; if (nib !== 4'hD) begin nerr++; $display("FAIL basic_nib: got %h want d", nib); end
  endtask

  task automatic test_overflow();
    do_reset();
    send_nib(4'h5, 1'b1);
    send_nib(4'hA, 1'b0);
    ncmp++; if (ovf !== 1'b0) begin nerr++; $display("FAIL ovf_before: got %b want 0", ovf); end
    ncmp++; if (nib !== 4'h5) begin nerr++; $display("FAIL ovf_head: got %h want 5", nib); end
    send_nib(4'h3, 1'b0);
    ncmp++; if (ovf !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", ovf); end
    ncmp++; if (ovf_f !== 1'b0) begin nerr++; $display("FAIL ovf_frame_limited: got %b want 0", ovf_f); end
    NIB_READY = 1'b1;
    @(negedge CLK);
    ncmp++; if (nib !== 4'hA || valid !== 1'b1) begin nerr++; $display("FAIL ovf_drain1: got %h/%b want a/1", nib, valid); end
    @(negedge CLK);
    NIB_READY = 1'b0;
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL ovf_drain2: got %b want 0", valid); end
    ncmp++; if (ovf !== 1'b1) begin nerr++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_reset_mid_frame();
    send_nib(4'h6, 1'b1);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    CLR = 1'b0;
    #1;
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b want 0", valid); end
    ncmp++; if (ovf !== 1'b0) begin nerr++; $display("FAIL midrst_ovf: got %b want 0", ovf); end
    ncmp++; if (nib !== 4'h0) begin nerr++; $display("FAIL midrst_nib: got %h want 0", nib); end
    @(negedge CLK);
    CLR = 1'b1;
    // No SYNC after reset: bits are ignored in HUNT.
    send_nib(4'hD, 1'b0);
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL hunt_ignore: got %b want 0", valid); end
  endtask

  task automatic test_half_rate();
    do_reset();
    send_bit(1'b1, 1'b1); idle(1);
    send_bit(1'b0, 1'b0); idle(1);
    send_bit(1'b1, 1'b0); idle(1);
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL half_early_valid: got %b want 0", valid); end
    send_bit(1'b1, 1'b0);
    ncmp++; if (valid !== 1'b1 || nib !== 4'hD) begin nerr++; $display("FAIL half_nib1: got %h/%b want d/1", nib, valid); end
    idle(1);
`ifdef NIBCAP_PARITY_EN
    send_bit(1'b1, 1'b0); idle(1);
`endif
    send_data(4'hA, 1'b0, 1);
`ifdef NIBCAP_PARITY_EN
    send_bit(1'b0, 1'b0); idle(1);
`endif
    ncmp++; if (nib !== 4'hD) begin nerr++; $display("FAIL half_head: got %h want d", nib); end
    NIB_READY = 1'b1;
    @(negedge CLK);
    ncmp++; if (valid !== 1'b1 || nib !== 4'hA) begin nerr++; $display("FAIL half_nib2: got %h/%b want a/1", nib, valid); end
    @(negedge CLK);
    NIB_READY = 1'b0;
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL half_drained: got %b want 0", valid); end
  endtask

  task automatic test_resync();
    do_reset();
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0);
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL resync_no_partial: got %b want 0", valid); end
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    ncmp++; if (valid !== 1'b1 || nib !== 4'h6) begin nerr++; $display("FAIL resync_nib: got %h/%b want 6/1", nib, valid); end
  endtask

  task automatic test_frame();
    do_reset();
    send_nib(4'h1, 1'b1);
    send_nib(4'h2, 1'b0);
    send_nib(4'h3, 1'b0);
    ncmp++; if (valid_f !== 1'b1 || nib_f !== 4'h1) begin nerr++; $display("FAIL frame_head: got %h/%b want 1/1", nib_f, valid_f); end
    ncmp++; if (ovf_f !== 1'b0) begin nerr++; $display("FAIL frame_ovf: got %b want 0", ovf_f); end
    NIB_READY = 1'b1;
    @(negedge CLK);
    ncmp++; if (nib_f !== 4'h2) begin nerr++; $display("FAIL frame_second: got %h want 2", nib_f); end
    @(negedge CLK);
    NIB_READY = 1'b0;
    ncmp++; if (valid_f !== 1'b0) begin nerr++; $display("FAIL frame_only_two: got %b want 0", valid_f); end
    idle(2);
    send_nib(4'h9, 1'b1);
    ncmp++; if (valid_f !== 1'b1 || nib_f !== 4'h9) begin nerr++; $display("FAIL frame_resume: got %h/%b want 9/1", nib_f, valid_f); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    NIB_READY = 1'b1;
    send_data(4'h3, 1'b1, 0);
    ncmp++; if (valid !== 1'b1 || nib !== 4'h3) begin nerr++; $display("FAIL b2b_first: got %h/%b want 3/1", nib, valid); end
`ifdef NIBCAP_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    send_data(4'hC, 1'b0, 0);
    ncmp++; if (valid !== 1'b1 || nib !== 4'hC) begin nerr++; $display("FAIL b2b_second: got %h/%b want c/1", nib, valid); end
`ifdef NIBCAP_PARITY_EN
    send_bit(1'b0, 1'b0);
`else
    idle(1);
`endif
    ncmp++; if (valid !== 1'b0) begin nerr++; $display("FAIL b2b_drained: got %b want 0", valid); end
    // Push into a full FIFO while a pop frees a slot: no overflow.
    NIB_READY = 1'b0;
    send_nib(4'h1, 1'b0);
    send_nib(4'h2, 1'b0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    NIB_READY = 1'b1;
    send_bit(1'b0, 1'b0);
    NIB_READY = 1'b0;
    ncmp++; if (ovf !== 1'b0) begin nerr++; $display("FAIL full_pushpop_ovf: got %b want 0", ovf); end
    ncmp++; if (valid !== 1'b1 || nib !== 4'h2) begin nerr++; $display("FAIL full_pushpop_head: got %h/%b want 2/1", nib, valid); end
`ifdef NIBCAP_PARITY_EN
    send_bit(1'b1, 1'b0);
`endif
    NIB_READY = 1'b1;
    @(negedge CLK);
    NIB_READY = 1'b0;
    ncmp++; if (valid !== 1'b1 || nib !== 4'h7) begin nerr++; $display("FAIL full_pushpop_tail: got %h/%b want 7/1", nib, valid); end
  endtask

`ifdef NIBCAP_PARITY_EN
  task automatic test_parity();
    do_reset();
    send_data(4'h7, 1'b1, 0);
    send_bit(1'b0, 1'b0);
    ncmp++; if (perr !== 1'b1) begin nerr++; $display("FAIL par_err_pulse: got %b want 1", perr); end
    idle(1);
    ncmp++; if (perr !== 1'b0) begin nerr++; $display("FAIL par_err_one_cycle: got %b want 0", perr); end
    ncmp++; if (valid !== 1'b1 || nib !== 4'h7) begin nerr++; $display("FAIL par_still_buffered: got %h/%b want 7/1", nib, valid); end
    send_data(4'h7, 1'b0, 0);
    send_bit(1'b1, 1'b0);
    ncmp++; if (perr !== 1'b0) begin nerr++; $display("FAIL par_ok: got %b want 0", perr); end
  endtask
`endif

  initial begin
    ncmp = 0; nerr = 0;
    CLK = 1'b0; CLR = 1'b0; BIT_EN = 1'b0; SIN = 1'b0; SYNC = 1'b0; NIB_READY = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_reset_mid_frame();
    test_half_rate();
    test_resync();
    test_frame();
    test_back_to_back();
`ifdef NIBCAP_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
